// File: rtl/apb_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | apb_pkg : shared states and bus widths for the APB requester bridge    |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SETUP  = 2'b01,
    ACCESS = 2'b10
  } apb_state_e;

  localparam int APB_ADDR_W = 32;
  localparam int APB_DATA_W = 32;
  localparam int APB_STRB_W = 4;
  localparam int APB_PROT_W = 3;

  localparam logic [APB_STRB_W-1:0] READ_STRB = 4'b0000;

endpackage
`default_nettype wire

// File: rtl/apb_master_arbiter_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | apb_master_arbiter_if : requester-side and APB completer-side signals  |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
interface apb_master_arbiter_if
  import apb_pkg::*;
#(
  parameter int NUM_REQ = 2
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_write;
  logic [NUM_REQ*APB_ADDR_W-1:0] req_addr;
  logic [NUM_REQ*APB_DATA_W-1:0] req_wdata;
  logic [NUM_REQ*APB_STRB_W-1:0] req_strb;
  logic [NUM_REQ*APB_PROT_W-1:0] req_prot;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ-1:0]            rsp_valid;
  logic [APB_DATA_W-1:0]         rsp_rdata;
  logic                          rsp_err;

  logic                          PSEL;
  logic                          PENABLE;
  logic                          PWRITE;
  logic [APB_ADDR_W-1:0]         PADDR;
  logic [APB_DATA_W-1:0]         PWDATA;
  logic [APB_STRB_W-1:0]         PSTRB;
  logic [APB_PROT_W-1:0]         PPROT;
  logic [APB_DATA_W-1:0]         PRDATA;
  logic                          PREADY;
  logic                          PSLVERR;
  logic                          busy;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, req_strb, req_prot,
    input  PRDATA, PREADY, PSLVERR,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT, busy
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, req_strb, req_prot,
    output PRDATA, PREADY, PSLVERR,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT, busy
  );

endinterface
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | rr_arbiter : round-robin one-hot arbiter, pointer advances on grant    |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module rr_arbiter #(
  parameter  int NUM_REQ = 2,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] i_req,
  input  logic               i_en,
  output logic [NUM_REQ-1:0] o_gnt,
  output logic [IDX_W-1:0]   o_gnt_idx
);

  logic [IDX_W-1:0]   r_ptr;
  logic [IDX_W-1:0]   w_cand;
  logic [IDX_W-1:0]   w_idx;
  logic               w_found;
  logic [NUM_REQ-1:0] w_gnt;

  function automatic logic [IDX_W-1:0] wrap_idx(input int base, input int off);
    int s;
    s = base + off;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return IDX_W'(s);
  endfunction

  // r_ptr is the first requester considered: one past the last winner
  always_comb begin
    w_cand  = '0;
    w_idx   = '0;
    w_found = 1'b0;
    w_gnt   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_cand = wrap_idx(int'(r_ptr), i);
      if (!w_found && i_req[w_cand]) begin
        w_found = 1'b1;
        w_idx   = w_cand;
      end
    end
    if (w_found && i_en) w_gnt[w_idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (i_en && w_found) begin
      r_ptr <= wrap_idx(int'(w_idx), 1);
    end
  end

  assign o_gnt     = w_gnt;
  assign o_gnt_idx = w_idx;

endmodule
`default_nettype wire

// File: rtl/apb_master_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | apb_master_arbiter : shares one APB4 completer among NUM_REQ requesters|
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module apb_master_arbiter
  import apb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int TIMEOUT = 16
) (
  input  logic                 PCLK,
  input  logic                 PRESETn,
  apb_master_arbiter_if.master bus
);

  localparam int IDX_W  = $clog2(NUM_REQ);
  localparam int TCNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  apb_state_e            r_state;
  apb_state_e            w_state_nxt;
  logic                  w_any;
  logic                  w_tmo;
  logic                  w_done;
  logic                  w_gnt_en;
  logic [NUM_REQ-1:0]    w_gnt;
  logic [IDX_W-1:0]      w_gnt_idx;

  logic [IDX_W-1:0]      r_owner;
  logic                  r_write;
  logic [APB_ADDR_W-1:0] r_addr;
  logic [APB_DATA_W-1:0] r_wdata;
  logic [APB_STRB_W-1:0] r_strb;
  logic [APB_PROT_W-1:0] r_prot;
  logic [TCNT_W-1:0]     r_tcnt;
  logic [NUM_REQ-1:0]    r_rsp_valid;
  logic [APB_DATA_W-1:0] r_rsp_rdata;
  logic                  r_rsp_err;

  // Gating with PRESETn keeps req_ready low while reset is held
  assign w_any  = PRESETn && (|bus.req_valid);
  // The timeout cycle is the TIMEOUT-th ACCESS cycle without PREADY
  assign w_tmo  = (TIMEOUT != 0) && !bus.PREADY && (r_tcnt == TCNT_LAST);
  assign w_done = (r_state == ACCESS) && (bus.PREADY || w_tmo);

  always_comb begin
    w_state_nxt = r_state;
    w_gnt_en    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_any) begin
          w_gnt_en    = 1'b1;
          w_state_nxt = SETUP;
        end
      end
      SETUP: w_state_nxt = ACCESS;
      ACCESS: begin
        if (w_done) begin
          if (w_any) begin
            w_gnt_en    = 1'b1;
            w_state_nxt = SETUP;
          end else begin
            w_state_nxt = IDLE;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr_arbiter (
    .clk       (PCLK),
    .rst_n     (PRESETn),
    .i_req     (bus.req_valid),
    .i_en      (w_gnt_en),
    .o_gnt     (w_gnt),
    .o_gnt_idx (w_gnt_idx)
  );

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_owner <= '0;
      r_write <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_strb  <= '0;
      r_prot  <= '0;
    end else if (w_gnt_en) begin
      r_owner <= w_gnt_idx;
      r_write <= bus.req_write[w_gnt_idx];
      r_addr  <= bus.req_addr[int'(w_gnt_idx)*APB_ADDR_W +: APB_ADDR_W];
      r_wdata <= bus.req_wdata[int'(w_gnt_idx)*APB_DATA_W +: APB_DATA_W];
      r_strb  <= bus.req_write[w_gnt_idx]
                 ? bus.req_strb[int'(w_gnt_idx)*APB_STRB_W +: APB_STRB_W]
                 : READ_STRB;
      r_prot  <= bus.req_prot[int'(w_gnt_idx)*APB_PROT_W +: APB_PROT_W];
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_tcnt <= '0;
    end else if ((TIMEOUT != 0) && (r_state == ACCESS) && !w_done) begin
      r_tcnt <= r_tcnt + TCNT_W'(1);
    end else begin
      r_tcnt <= '0;
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_rsp_valid <= '0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_rsp_valid <= '0;
      if (w_done) begin
        r_rsp_valid <= NUM_REQ'(1) << r_owner;
        r_rsp_rdata <= (bus.PREADY && !r_write) ? bus.PRDATA : '0;
        r_rsp_err   <= bus.PREADY ? bus.PSLVERR : 1'b1;
      end
    end
  end

  assign bus.req_ready = w_gnt;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_rdata = r_rsp_rdata;
  assign bus.rsp_err   = r_rsp_err;
  assign bus.PSEL      = (r_state != IDLE);
  assign bus.PENABLE   = (r_state == ACCESS);
  assign bus.busy      = (r_state != IDLE);
  assign bus.PWRITE    = r_write;
  assign bus.PADDR     = r_addr;
  assign bus.PWDATA    = r_wdata;
  assign bus.PSTRB     = r_strb;
  assign bus.PPROT     = r_prot;

endmodule
`default_nettype wire

// File: tb/tb_apb_master_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_apb_master_arbiter : random + directed bench with transaction model |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module tb_apb_master_arbiter;
  import apb_pkg::*;

  localparam int N  = 3;
  localparam int TO = 4;

  logic PCLK    = 1'b0;
  logic PRESETn = 1'b0;

  apb_master_arbiter_if #(.NUM_REQ(N)) bus ();

  apb_master_arbiter #(.NUM_REQ(N), .TIMEOUT(TO)) dut (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .bus     (bus)
  );

  always #5 PCLK = ~PCLK;

  int checks = 0;
  int errors = 0;

  // requester-side stimulus
  logic [N-1:0] v_drive;
  logic         q_write [N];
  logic [31:0]  q_addr  [N];
  logic [31:0]  q_wdata [N];
  logic [3:0]   q_strb  [N];
  logic [2:0]   q_prot  [N];
  int           regen_idx  = -1;
  bit           rand_valid = 0;
  bit           force_write = 0;
  int           wait_mode = 0;
  int           err_mode  = 0;

  // transaction-level reference
  logic [31:0]  mem [16];
  int           phase = 0;       // bus phase expected next cycle: 0 idle, 1 setup, 2 access
  int           last_g = N - 1;
  int           cur_idx, cur_wait, acc_cnt;
  logic         cur_write;
  logic [31:0]  cur_addr, cur_wdata;
  logic [3:0]   cur_strb;
  logic [2:0]   cur_prot;
  logic [N-1:0] exp_rsp_v = '0;
  logic [31:0]  exp_rdata = '0;
  logic         exp_err   = 1'b0;
  int           grants [N];
  int           rsp_seen = 0;
  logic [31:0]  last_rdata = '0;
  logic         last_err   = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic regen(input int i);
    q_write[i] = force_write ? 1'b1 : 1'($urandom_range(0, 1));
    q_addr[i]  = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
    q_wdata[i] = $urandom;
    q_strb[i]  = 4'($urandom_range(0, 15));
    q_prot[i]  = 3'($urandom_range(0, 7));
  endtask

  task automatic drive_bus();
    for (int i = 0; i < N; i++) begin
      bus.req_write[i]          = q_write[i];
      bus.req_addr[32*i +: 32]  = q_addr[i];
      bus.req_wdata[32*i +: 32] = q_wdata[i];
      bus.req_strb[4*i +: 4]    = q_strb[i];
      bus.req_prot[3*i +: 3]    = q_prot[i];
    end
    bus.req_valid = v_drive;
  endtask

  // One clock cycle: check registered outputs, play completer, check grant.
  task automatic step();
    int   g;
    logic done;
    logic [N-1:0] exp_rdy;
    logic [31:0]  rd;
    logic         serr;
    @(negedge PCLK);
    if (regen_idx >= 0) begin
      regen(regen_idx);
      regen_idx = -1;
    end
    check_eq("psel",    32'(bus.PSEL),    32'(phase != 0));
    check_eq("penable", 32'(bus.PENABLE), 32'(phase == 2));
    check_eq("busy",    32'(bus.busy),    32'(phase != 0));
    if (phase != 0) begin
      check_eq("paddr",  bus.PADDR,          cur_addr);
      check_eq("pwrite", 32'(bus.PWRITE),    32'(cur_write));
      check_eq("pwdata", bus.PWDATA,         cur_wdata);
      check_eq("pstrb",  32'(bus.PSTRB),     cur_write ? 32'(cur_strb) : 32'(0));
      check_eq("pprot",  32'(bus.PPROT),     32'(cur_prot));
    end
    check_eq("rsp_valid", 32'(bus.rsp_valid), 32'(exp_rsp_v));
    if (exp_rsp_v != '0) begin
      check_eq("rsp_rdata", bus.rsp_rdata,     exp_rdata);
      check_eq("rsp_err",   32'(bus.rsp_err),  32'(exp_err));
    end
    if (bus.rsp_valid != '0) begin
      rsp_seen++;
      last_rdata = bus.rsp_rdata;
      last_err   = bus.rsp_err;
    end

    done       = 1'b0;
    rd         = $urandom;
    serr       = 1'($urandom_range(0, 1));
    bus.PREADY = 1'($urandom_range(0, 1));
    if (phase == 2) begin
      acc_cnt++;
      if (acc_cnt > cur_wait) begin
        bus.PREADY = 1'b1;
        serr = (err_mode >= 0) ? 1'(err_mode) : ($urandom_range(0, 5) == 0);
        if (!cur_write) rd = mem[cur_addr[5:2]];
        done      = 1'b1;
        exp_rdata = cur_write ? 32'd0 : rd;
        exp_err   = serr;
        if (cur_write && !serr)
          for (int b = 0; b < 4; b++)
            if (cur_strb[b]) mem[cur_addr[5:2]][8*b +: 8] = cur_wdata[8*b +: 8];
      end else begin
        bus.PREADY = 1'b0;
        if (acc_cnt == TO) begin
          done      = 1'b1;
          exp_rdata = 32'd0;
          exp_err   = 1'b1;
        end
      end
    end
    bus.PRDATA  = rd;
    bus.PSLVERR = serr;
    if (rand_valid)
      for (int i = 0; i < N; i++) v_drive[i] = ($urandom_range(0, 3) != 0);
    drive_bus();
    #1;
    exp_rdy = '0;
    g = -1;
    if ((phase == 0 || done) && v_drive != '0) begin
      for (int k = 1; k <= N; k++) begin
        int c;
        c = (last_g + k) % N;
        if (g < 0 && v_drive[c]) g = c;
      end
      exp_rdy[g] = 1'b1;
    end
    check_eq("req_ready", 32'(bus.req_ready), 32'(exp_rdy));

    exp_rsp_v = done ? (N'(1) << cur_idx) : '0;
    if (g >= 0) begin
      cur_idx   = g;
      cur_write = q_write[g];
      cur_addr  = q_addr[g];
      cur_wdata = q_wdata[g];
      cur_strb  = q_strb[g];
      cur_prot  = q_prot[g];
      cur_wait  = (wait_mode >= 0) ? wait_mode : $urandom_range(0, 5);
      acc_cnt   = 0;
      last_g    = g;
      grants[g]++;
      phase     = 1;
      regen_idx = g;
    end else if (done) begin
      phase = 0;
    end else if (phase == 1) begin
      phase = 2;
    end
  endtask

  task automatic idle_wait();
    int n;
    n = 0;
    while (phase != 0 && n < 20) begin
      step();
      n++;
    end
    step();
    check_eq("idle_budget", 32'(phase), 32'd0);
  endtask

  task automatic set_req0(input logic w, input logic [31:0] a, input logic [31:0] d);
    q_write[0] = w;
    q_addr[0]  = a;
    q_wdata[0] = d;
    q_strb[0]  = 4'hF;
    q_prot[0]  = 3'd2;
  endtask

  initial begin
    int g1_before;
    for (int i = 0; i < 16; i++) mem[i] = '0;
    for (int i = 0; i < N; i++) begin
      grants[i] = 0;
      regen(i);
    end
    v_drive     = '0;
    drive_bus();
    bus.PREADY  = 1'b0;
    bus.PSLVERR = 1'b0;
    bus.PRDATA  = '0;
    repeat (3) @(negedge PCLK);
    check_eq("rst_psel",      32'(bus.PSEL),      32'd0);
    check_eq("rst_penable",   32'(bus.PENABLE),   32'd0);
    check_eq("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check_eq("rst_paddr",     bus.PADDR,          32'd0);
    PRESETn = 1'b1;

    // single write then read at 0x10
    wait_mode = 0; err_mode = 0;
    set_req0(1'b1, 32'h10, 32'hA5A5_1234);
    v_drive = 3'b001; step();
    v_drive = 3'b000; step(); step(); step();
    check_eq("wr_err", 32'(last_err), 32'd0);
    set_req0(1'b0, 32'h10, 32'h0);
    v_drive = 3'b001; step();
    v_drive = 3'b000; idle_wait();
    check_eq("rd_data", last_rdata, 32'hA5A5_1234);
    check_eq("rd_err",  32'(last_err), 32'd0);

    // contention: two requesters, writes only
    force_write = 1; regen(0); regen(1);
    grants[0] = 0; grants[1] = 0; rsp_seen = 0;
    v_drive = 3'b011;
    repeat (16) step();
    v_drive = 3'b000;
    repeat (2) step();
    force_write = 0;
    check_eq("cont_g0",  32'(grants[0]), 32'd4);
    check_eq("cont_g1",  32'(grants[1]), 32'd4);
    check_eq("cont_rsp", 32'(rsp_seen),  32'd8);
    idle_wait();

    // wait states with slave error
    wait_mode = 3; err_mode = 1;
    set_req0(1'b1, 32'h20, 32'h1234_5678);
    v_drive = 3'b001; step();
    v_drive = 3'b000; idle_wait();
    check_eq("ws_err", 32'(last_err), 32'd1);

    // timeout on a read, then a normal read
    wait_mode = 99; err_mode = 0;
    set_req0(1'b0, 32'h10, 32'h0);
    v_drive = 3'b001; step();
    v_drive = 3'b000; idle_wait();
    check_eq("to_err",   32'(last_err), 32'd1);
    check_eq("to_rdata", last_rdata,    32'd0);
    wait_mode = 0;
    set_req0(1'b0, 32'h10, 32'h0);
    v_drive = 3'b001; step();
    v_drive = 3'b000; idle_wait();
    check_eq("post_to_rdata", last_rdata, 32'hA5A5_1234);

    // asynchronous reset during ACCESS
    wait_mode = 10;
    set_req0(1'b1, 32'h30, 32'hDEAD_BEEF);
    v_drive = 3'b001; step();
    v_drive = 3'b000; step();
    v_drive = 3'b011; drive_bus();
    @(posedge PCLK);
    #2 PRESETn = 1'b0;
    #1;
    check_eq("ar_psel",      32'(bus.PSEL),      32'd0);
    check_eq("ar_penable",   32'(bus.PENABLE),   32'd0);
    check_eq("ar_busy",      32'(bus.busy),      32'd0);
    check_eq("ar_req_ready", 32'(bus.req_ready), 32'd0);
    check_eq("ar_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check_eq("ar_paddr",     bus.PADDR,          32'd0);
    check_eq("ar_pwdata",    bus.PWDATA,         32'd0);
    check_eq("ar_rsp_err",   32'(bus.rsp_err),   32'd0);
    bus.req_valid = '0;
    @(negedge PCLK);
    PRESETn   = 1'b1;
    phase     = 0;
    last_g    = N - 1;
    exp_rsp_v = '0;
    wait_mode = 0;
    v_drive = 3'b011; step();
    v_drive = 3'b000; idle_wait();

    // requester 1 pulses valid while requester 0 owns the bus
    wait_mode = 3;
    g1_before = grants[1];
    v_drive = 3'b001; step();
    v_drive = 3'b000; step();
    v_drive = 3'b010; step();
    v_drive = 3'b000; idle_wait();
    check_eq("drop_g1", 32'(grants[1]), 32'(g1_before));

    // randomized traffic
    wait_mode = -1; err_mode = -1; rand_valid = 1;
    repeat (1500) step();
    rand_valid = 0; v_drive = '0;
    idle_wait();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
`default_nettype wire
